// File: rtl/chart_rom_arbiter.sv
// Round-robin arbiter sharing one combinational chart-ROM read port among num_req_p requesters.
// Optional CHART_ROM_ARB_PERF_EN adds saturating grant/conflict counters (grant_cnt_o, conflict_cnt_o).
module chart_rom_arbiter #(
    parameter int width_p   = 8,
    parameter int depth_p   = 128,
    parameter int num_req_p = 4,
    localparam int addr_w   = $clog2(depth_p),
    localparam int idx_w    = $clog2(num_req_p)
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic [num_req_p-1:0]        req_valid_i,
    input  logic [num_req_p*addr_w-1:0] req_addr_i,
    output logic [num_req_p-1:0]        req_ready_o,
    output logic [num_req_p-1:0]        resp_valid_o,
    input  logic [num_req_p-1:0]        resp_ready_i,
    output logic [width_p-1:0]          resp_data_o,
    output logic                        resp_err_o,
    output logic [addr_w-1:0]           rom_addr_o,
    input  logic [width_p-1:0]          rom_data_i
`ifdef CHART_ROM_ARB_PERF_EN
    ,
    output logic [15:0]                 grant_cnt_o,
    output logic [15:0]                 conflict_cnt_o
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [idx_w-1:0]   rr_ptr;
    logic [idx_w-1:0]   owner;
    logic               err_r;

    logic               grant_any;
    logic [idx_w-1:0]   winner;
    logic [addr_w-1:0]  win_addr;
    logic               win_err;
    int unsigned        cand;

    // Handshake: a request is consumed on the cycle req_valid_i[k] & req_ready_o[k];
    // a response is consumed on resp_valid_o[owner] & resp_ready_i[owner].

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        grant_any = 1'b0;
        winner    = '0;
        cand      = 0;
        for (int i = 0; i < num_req_p; i++) begin
            cand = (int'(rr_ptr) + i) % num_req_p;
            if (!grant_any && req_valid_i[cand]) begin
                grant_any = 1'b1;
                winner    = idx_w'(cand);
            end
        end
    end

    assign win_addr = req_addr_i[int'(winner)*addr_w +: addr_w];
    assign win_err  = int'(win_addr) >= depth_p;

    always_comb begin
        state_next   = state;
        req_ready_o  = '0;
        resp_valid_o = '0;
        case (state)
            IDLE: begin
                if (grant_any && reset_n_i) begin
                    req_ready_o[winner] = 1'b1;
                    state_next          = LOOKUP;
                end
            end
            LOOKUP: state_next = RESP;
            RESP: begin
                resp_valid_o[owner] = 1'b1;
                if (resp_ready_i[owner]) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            owner       <= '0;
            err_r       <= 1'b0;
            rom_addr_o  <= '0;
            resp_data_o <= '0;
            resp_err_o  <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        owner      <= winner;
                        rom_addr_o <= win_addr;
                        err_r      <= win_err;
                        rr_ptr     <= (winner == idx_w'(num_req_p - 1)) ? '0 : winner + 1'b1;
                    end
                end
                LOOKUP: begin
                    // Out-of-range lookups still drive the ROM but return zero data.
                    resp_data_o <= err_r ? '0 : rom_data_i;
                    resp_err_o  <= err_r;
                end
                default: ;
            endcase
        end
    end

`ifdef CHART_ROM_ARB_PERF_EN
    logic grant_fire;
    logic conflict;

    assign grant_fire = (state == IDLE) && grant_any;
    // Only one requester can be granted per cycle, so two or more valids always leave one waiting.
    assign conflict   = $countones(req_valid_i) >= 2;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            grant_cnt_o    <= '0;
            conflict_cnt_o <= '0;
        end else begin
            if (grant_fire && grant_cnt_o != 16'hFFFF) grant_cnt_o <= grant_cnt_o + 16'd1;
            if (conflict && conflict_cnt_o != 16'hFFFF) conflict_cnt_o <= conflict_cnt_o + 16'd1;
        end
    end
`else
    // Performance counters are not built in this configuration.
`endif

endmodule
